// File: rtl/demux_1to4_seq.sv
// 1-to-4 demultiplexer with a one-entry holding register per lane and a manual or round-robin target.
// The target lane is taken from sel or from the internal pointer. Lane outputs appear one cycle after accept.
module demux_1to4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             auto,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr
);

  logic [WIDTH-1:0] lane_q [4];
  logic [WIDTH-1:0] lane_d [4];
  logic [3:0]       vld_q, vld_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       tgt;
  logic             xfer;

  always_comb begin
    tgt      = auto ? ptr_q : sel;
    // A full target lane that is draining this cycle can take a new word.
    in_ready = ~vld_q[tgt] | out_ready[tgt];
    xfer     = in_valid & in_ready;

    lane_d = lane_q;
    vld_d  = vld_q & ~out_ready;
    if (xfer) begin
      lane_d[tgt] = in;
      vld_d[tgt]  = 1'b1;
    end

    ptr_d = (xfer && auto) ? ptr_q + 2'd1 : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      vld_q <= 4'b0000;
      ptr_q <= 2'b00;
    end else begin
      lane_q <= lane_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign a         = lane_q[0];
  assign b         = lane_q[1];
  assign c         = lane_q[2];
  assign d         = lane_q[3];
  assign out_valid = vld_q;
  assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_demux_1to4_seq.sv
// Directed, table-driven bench for demux_1to4_seq.
// Each vector applies inputs, checks in_ready before the edge, and checks the registered state after it.
module tb_demux_1to4_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       auto;
  logic [3:0] a, b, c, d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;

  int checks;
  int failures;

  demux_1to4_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .auto      (auto),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  din;
    logic        iv;
    logic [1:0]  sel;
    logic        au;
    logic [3:0]  ord;
    logic        exp_ir;
    logic [15:0] exp_lanes;  // {d,c,b,a}
    logic [3:0]  exp_ov;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic [3:0] din, input logic iv, input logic [1:0] s,
                              input logic au, input logic [3:0] ord, input logic eir,
                              input logic [15:0] elanes, input logic [3:0] eov,
                              input logic [1:0] eptr);
    vec_t v;
    v.din = din; v.iv = iv; v.sel = s; v.au = au; v.ord = ord;
    v.exp_ir = eir; v.exp_lanes = elanes; v.exp_ov = eov; v.exp_ptr = eptr;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] lanes, input logic [3:0] ov,
                             input logic [1:0] ptr);
    check({tag, ".lanes"}, {d, c, b, a}, lanes);
    check({tag, ".out_valid"}, {12'd0, out_valid}, {12'd0, ov});
    check({tag, ".rr_ptr"}, {14'd0, rr_ptr}, {14'd0, ptr});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // manual routing and drain
    vecs[0]  = mk(4'h1, 1, 2'd0, 0, 4'h0, 1, 16'h0001, 4'b0001, 2'd0);
    vecs[1]  = mk(4'h2, 1, 2'd1, 0, 4'h0, 1, 16'h0021, 4'b0011, 2'd0);
    vecs[2]  = mk(4'h3, 1, 2'd2, 0, 4'h0, 1, 16'h0321, 4'b0111, 2'd0);
    vecs[3]  = mk(4'h4, 1, 2'd3, 0, 4'h0, 1, 16'h4321, 4'b1111, 2'd0);
    vecs[4]  = mk(4'h0, 0, 2'd0, 0, 4'hf, 1, 16'h4321, 4'b0000, 2'd0);
    // backpressure on lane b, then load-over-drain
    vecs[5]  = mk(4'h5, 1, 2'd1, 0, 4'h0, 1, 16'h4351, 4'b0010, 2'd0);
    vecs[6]  = mk(4'h6, 1, 2'd1, 0, 4'h0, 0, 16'h4351, 4'b0010, 2'd0);
    vecs[7]  = mk(4'h6, 1, 2'd1, 0, 4'b0010, 1, 16'h4361, 4'b0010, 2'd0);
    vecs[8]  = mk(4'h0, 0, 2'd1, 0, 4'hf, 1, 16'h4361, 4'b0000, 2'd0);
    // round-robin with wrap
    vecs[9]  = mk(4'h0, 1, 2'd0, 1, 4'hf, 1, 16'h4360, 4'b0001, 2'd1);
    vecs[10] = mk(4'h1, 1, 2'd0, 1, 4'hf, 1, 16'h4310, 4'b0010, 2'd2);
    vecs[11] = mk(4'h2, 1, 2'd0, 1, 4'hf, 1, 16'h4210, 4'b0100, 2'd3);
    vecs[12] = mk(4'h3, 1, 2'd0, 1, 4'hf, 1, 16'h3210, 4'b1000, 2'd0);
    vecs[13] = mk(4'h4, 1, 2'd0, 1, 4'hf, 1, 16'h3214, 4'b0001, 2'd1);
    vecs[14] = mk(4'h5, 1, 2'd0, 1, 4'hf, 1, 16'h3254, 4'b0010, 2'd2);
    vecs[15] = mk(4'h0, 0, 2'd0, 1, 4'hf, 1, 16'h3254, 4'b0000, 2'd2);
    // mode toggle at rr_ptr=3
    vecs[16] = mk(4'h7, 1, 2'd0, 1, 4'hf, 1, 16'h3754, 4'b0100, 2'd3);
    vecs[17] = mk(4'h9, 1, 2'd0, 0, 4'hf, 1, 16'h3759, 4'b0001, 2'd3);
    vecs[18] = mk(4'ha, 1, 2'd0, 1, 4'hf, 1, 16'ha759, 4'b1000, 2'd0);
    vecs[19] = mk(4'h0, 0, 2'd0, 1, 4'hf, 1, 16'ha759, 4'b0000, 2'd0);
    // round-robin stall
    vecs[20] = mk(4'h1, 1, 2'd0, 1, 4'h0, 1, 16'ha751, 4'b0001, 2'd1);
    vecs[21] = mk(4'h2, 1, 2'd0, 1, 4'h0, 1, 16'ha721, 4'b0011, 2'd2);
    vecs[22] = mk(4'h3, 1, 2'd0, 1, 4'h0, 1, 16'ha321, 4'b0111, 2'd3);
    vecs[23] = mk(4'h4, 1, 2'd0, 1, 4'h0, 1, 16'h4321, 4'b1111, 2'd0);
    vecs[24] = mk(4'h5, 1, 2'd0, 1, 4'h0, 0, 16'h4321, 4'b1111, 2'd0);
    vecs[25] = mk(4'h5, 1, 2'd2, 1, 4'h0, 0, 16'h4321, 4'b1111, 2'd0);
    vecs[26] = mk(4'h5, 1, 2'd2, 1, 4'b0001, 1, 16'h4325, 4'b1111, 2'd1);
    vecs[27] = mk(4'h6, 1, 2'd0, 1, 4'b0010, 1, 16'h4365, 4'b1111, 2'd2);
    // in_ready independent of in_valid; manual re-target while blocked
    vecs[28] = mk(4'h0, 0, 2'd0, 1, 4'h0, 0, 16'h4365, 4'b1111, 2'd2);
    vecs[29] = mk(4'h7, 1, 2'd3, 0, 4'h0, 0, 16'h4365, 4'b1111, 2'd2);

    rst_n = 1'b0; in = 4'h0; in_valid = 1'b0; sel = 2'd0; auto = 1'b0; out_ready = 4'h0;
    #1;
    check_state("reset", 16'h0000, 4'b0000, 2'd0);
    check("reset.in_ready", {15'd0, in_ready}, 16'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in = vecs[i].din; in_valid = vecs[i].iv; sel = vecs[i].sel;
      auto = vecs[i].au; out_ready = vecs[i].ord;
      #1;
      check($sformatf("v%0d.in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].exp_lanes, vecs[i].exp_ov, vecs[i].exp_ptr);
    end

    // reset asserted between edges with a word being offered
    @(negedge clk);
    in = 4'he; in_valid = 1'b1; auto = 1'b1; out_ready = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("midrst", 16'h0000, 4'b0000, 2'd0);
    check("midrst.in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    check_state("rsthold", 16'h0000, 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in = 4'hb; in_valid = 1'b1; auto = 1'b1; out_ready = 4'h0;
    @(posedge clk);
    #1;
    check_state("postrst", 16'h000b, 4'b0001, 2'd1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
